// File: rtl/gpio_event_log_pkg.sv
// rtl/gpio_event_log_pkg.sv - channel indices, record layout and clog2 helper for gpio_event_log
package gpio_event_log_pkg;

    localparam int GPIO_CH_IN  = 0;
    localparam int GPIO_CH_OUT = 1;
    localparam int GPIO_CH_DIR = 2;
    localparam int GPIO_NCH    = 3;
    localparam int DROP_W      = 16;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Record layout, LSB first: time | new {dir,out,in} | old {dir,out,in} | mask
    function automatic int rec_new_lsb(input int ts_w);
        return ts_w;
    endfunction

    function automatic int rec_old_lsb(input int width, input int ts_w);
        return ts_w + GPIO_NCH * width;
    endfunction

    function automatic int rec_mask_lsb(input int width, input int ts_w);
        return ts_w + 2 * GPIO_NCH * width;
    endfunction

    function automatic int rec_w(input int width, input int ts_w);
        return ts_w + 2 * GPIO_NCH * width + GPIO_NCH;
    endfunction

endpackage

// File: rtl/gpio_event_log_fifo.sv
// rtl/gpio_event_log_fifo.sv - gpio_evt_fifo: synchronous first-word-fall-through FIFO
module gpio_evt_fifo
    import gpio_event_log_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [DW-1:0]          head_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry a wrap bit so full and empty are distinguishable
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level     = wr_ptr - rd_ptr;
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_event_log.sv
// rtl/gpio_event_log.sv - GPIO change monitor with timestamped record FIFO; GPIO_LOG_TRACE_EN adds a sim trace
module gpio_event_log
    import gpio_event_log_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [WIDTH-1:0]       IN_I,
    input  logic [WIDTH-1:0]       OUT_I,
    input  logic [WIDTH-1:0]       DIR_I,
    input  logic                   EN_I,
    input  logic                   CLR_OVF_I,
    output logic                   EVT_VALID_O,
    input  logic                   EVT_READY_I,
    output logic [2:0]             EVT_MASK_O,
    output logic [3*WIDTH-1:0]     EVT_OLD_O,
    output logic [3*WIDTH-1:0]     EVT_NEW_O,
    output logic [TS_W-1:0]        EVT_TIME_O,
    output logic [clog2(DEPTH):0]  LEVEL_O,
    output logic                   OVF_O,
    output logic [DROP_W-1:0]      DROP_CNT_O
);

    localparam int REC_W    = rec_w(WIDTH, TS_W);
    localparam int NEW_LSB  = rec_new_lsb(TS_W);
    localparam int OLD_LSB  = rec_old_lsb(WIDTH, TS_W);
    localparam int MASK_LSB = rec_mask_lsb(WIDTH, TS_W);

    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_out;
    logic [WIDTH-1:0] sh_dir;
    logic             primed;
    logic [TS_W-1:0]  ts;
    logic [2:0]       mask;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head_rec;

    always_comb begin
        mask              = '0;
        mask[GPIO_CH_IN]  = (IN_I  != sh_in);
        mask[GPIO_CH_OUT] = (OUT_I != sh_out);
        mask[GPIO_CH_DIR] = (DIR_I != sh_dir);
    end

    assign push     = primed && EN_I && (|mask);
    assign pop      = EVT_VALID_O && EVT_READY_I;
    assign drop     = push && full && !pop;
    assign push_rec = {mask, sh_dir, sh_out, sh_in, DIR_I, OUT_I, IN_I, ts};

    // Shadows follow the buses even when disabled so re-enable sees no stale change
    always_ff @(posedge CLK_I) begin
        sh_in  <= IN_I;
        sh_out <= OUT_I;
        sh_dir <= DIR_I;
        if (RST_I) begin
            primed <= 1'b0;
            ts     <= '0;
        end else begin
            primed <= 1'b1;
            ts     <= ts + 1'b1;
        end
    end

    // A clear in the same cycle as a drop wins, and that drop goes uncounted
    always_ff @(posedge CLK_I) begin
        if (RST_I || CLR_OVF_I) begin
            OVF_O      <= 1'b0;
            DROP_CNT_O <= '0;
        end else if (drop) begin
            OVF_O <= 1'b1;
            if (DROP_CNT_O != '1) begin
                DROP_CNT_O <= DROP_CNT_O + 1'b1;
            end
        end
    end

    gpio_evt_fifo #(
        .DW    (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK_I),
        .rst       (RST_I),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head_data (head_rec),
        .full      (full),
        .empty     (empty),
        .level     (LEVEL_O)
    );

    assign EVT_VALID_O = !empty;
    assign EVT_TIME_O  = head_rec[TS_W-1:0];
    assign EVT_NEW_O   = head_rec[NEW_LSB +: 3*WIDTH];
    assign EVT_OLD_O   = head_rec[OLD_LSB +: 3*WIDTH];
    assign EVT_MASK_O  = head_rec[MASK_LSB +: 3];

`ifdef GPIO_LOG_TRACE_EN
    always @(posedge CLK_I) begin
        if (!RST_I && push && !drop) begin
            $write("GPIO evt t=%x mask=%b in %x->%x out %x->%x dir %x->%x\n",
                   ts, mask, sh_in, IN_I, sh_out, OUT_I, sh_dir, DIR_I);
        end
        if (!RST_I && drop) begin
            $write("GPIO evt dropped t=%x\n", ts);
        end
    end
`else
`endif

endmodule
